cache_line_arbiter: RTL and testbench
=====================================

Name: cache_line_arbiter

Overview:
- Shares one 256-bit line-granular memory port between the instruction cache and the data cache.
- Each cache's dfp port connects to one upward port here. The single downward port connects to memory/DRAM.
- Arbitration is round-robin between two requesters. One line transaction is outstanding at a time.
- The winning request is registered; the memory response is forwarded combinationally to the winner.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 256, cache line width in bits (32 bytes; line offset = 5 bits)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
i_addr  in  ADDR_WIDTH  icache line address
i_read  in  1  icache line read request
i_write  in  1  icache line write request (normally 0)
i_wdata  in  LINE_WIDTH  icache write line
i_rdata  out  LINE_WIDTH  read line to icache
i_resp  out  1  completion pulse to icache
d_addr  in  ADDR_WIDTH  dcache line address
d_read  in  1  dcache line read request
d_write  in  1  dcache write-back request
d_wdata  in  LINE_WIDTH  dcache write-back line
d_rdata  out  LINE_WIDTH  read line to dcache
d_resp  out  1  completion pulse to dcache
mem_addr  out  ADDR_WIDTH  memory line address, low 5 bits always 0
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_wdata  out  LINE_WIDTH  memory write line
mem_rdata  in  LINE_WIDTH  memory read line
mem_resp  in  1  memory completion, single-cycle pulse

Behaviour:
- Request contract:
  - A requester is pending when (read | write) = 1.
  - A requester holds addr/read/write/wdata stable until it sees its resp.
  - read & write together from one requester is illegal: flag by assertion; the arbiter treats it as a write.
- States: IDLE, BUSY.
- IDLE:
  - If neither requester is pending, stay in IDLE.
  - Otherwise choose a winner:
    - only one pending: that one wins;
    - both pending: the one not granted last wins.
  - On the cycle of the decision, latch the winner's addr (low 5 bits zeroed), read, write, wdata and owner id; update last_grant; go to BUSY.
- BUSY:
  - mem_addr, mem_read, mem_write, mem_wdata are driven only from the latched registers and are stable throughout BUSY.
  - mem_read/mem_write are 0 in IDLE.
  - When mem_resp = 1: assert owner's resp = 1 in the same cycle, drive owner's rdata = mem_rdata combinationally, then go to IDLE.
  - mem_resp while in IDLE is ignored (no resp is generated).
- Outputs:
  - i_resp/d_resp are 1 only in the BUSY & mem_resp cycle, and only for the owner.
  - The non-owner's rdata is 0.
- Latency:
  - A request first visible in cycle N gives mem_read/mem_write = 1 from cycle N+1.
  - resp arrives in the same cycle as mem_resp.
  - One mandatory IDLE cycle separates back-to-back transactions; this also filters the completing cache's still-asserted request in the resp cycle.
- Back-to-back from one requester: e.g. dcache write-back resp followed by an immediate read of a new address. The new request is seen in IDLE and arbitrated normally; if the other requester is waiting, the other wins.
- Reset, asynchronous, at any time including mid-BUSY:
  - state = IDLE, latched registers = 0, last_grant = dcache (so icache wins the first tie), all mem_* outputs = 0, both resp = 0.
  - Any in-flight memory transaction is abandoned; the memory model is reset together with the arbiter.
- Fairness: with both requesters continuously pending, grants strictly alternate. Worst-case wait = one transaction plus 1 IDLE cycle.
- Arbitration never changes during BUSY; a new request arriving in BUSY waits.

Test Plan:
- Reset then single icache read i_addr=0x0000_1234 → mem_addr=0x0000_1220, mem_read=1 from next cycle; memory returns 256'hA5… with mem_resp after 5 cycles → i_resp=1 and i_rdata=256'hA5… in that cycle; d_resp stays 0.
- i_read and d_read asserted in the same cycle after reset → icache granted first; after its mem_resp, one IDLE cycle, then dcache granted; d_resp on the second mem_resp.
- Both requesters held pending for 6 transactions → grant order I,D,I,D,I,D; the mem_* signals never change mid-BUSY.
- dcache write-back d_write=1, d_addr=0x8000_0040, d_wdata=256'h1234… then on d_resp switches to d_read at 0x0000_0100 while i_read is pending → order: write(0x8000_0040), icache read, dcache read(0x0000_0100).
- rst driven low mid-BUSY between clock edges → mem_read/mem_write drop to 0 immediately without waiting for a clock edge; after release with no requests, the arbiter stays IDLE; a later stray mem_resp produces no i_resp/d_resp.
- Held request after completion: i_read kept asserted for 1 cycle after i_resp → exactly one memory transaction; a new i_read held into the IDLE cycle starts a second transaction.

Source files
------------

// File: rtl/cache_line_arbiter.sv
// Round-robin arbiter sharing one line-granular memory port between icache and dcache.
// One transaction outstanding; the winner's request is latched, the response is forwarded combinationally.
module cache_line_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(5'h1f);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;  // 1 = dcache
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  i_pend_s, d_pend_s, win_s, done_s;

  assign i_pend_s = i_read | i_write;
  assign d_pend_s = d_read | d_write;

  // Winner selection: a tie goes to whoever was not granted last.
  always_comb begin
    win_s = 1'b0;
    if (i_pend_s && d_pend_s) begin
      win_s = ~last_q;
    end else if (d_pend_s) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state and latch logic; read+write together is demoted to a write.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    read_d  = read_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (i_pend_s || d_pend_s) begin
          state_d = BUSY;
          owner_d = win_s;
          last_d  = win_s;
          addr_d  = (win_s ? d_addr : i_addr) & ~OFFSET_MASK;
          write_d = win_s ? d_write : i_write;
          read_d  = (win_s ? d_read : i_read) & ~write_d;
          wdata_d = win_s ? d_wdata : i_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem_resp) begin
          state_d = IDLE;
          read_d  = 1'b0;
          write_d = 1'b0;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and latched request registers; reset leaves dcache as last grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_read  = read_q;
  assign mem_write = write_q;
  assign mem_wdata = wdata_q;

  assign done_s  = (state_q == BUSY) && mem_resp;
  assign i_resp  = done_s & ~owner_q;
  assign d_resp  = done_s & owner_q;
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;

  cache_line_arbiter_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_write   (i_write),
    .d_read    (d_read),
    .d_write   (d_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .i_resp    (i_resp),
    .d_resp    (d_resp)
  );

endmodule

// Protocol checker: illegal read+write requests and exclusivity of strobes and responses.
module cache_line_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic i_read,
  input logic i_write,
  input logic d_read,
  input logic d_write,
  input logic mem_read,
  input logic mem_write,
  input logic i_resp,
  input logic d_resp
);
  a_i_rw:   assert property (@(posedge clk) disable iff (!rst) !(i_read && i_write));
  a_d_rw:   assert property (@(posedge clk) disable iff (!rst) !(d_read && d_write));
  a_mem_rw: assert property (@(posedge clk) disable iff (!rst) !(mem_read && mem_write));
  a_resp:   assert property (@(posedge clk) disable iff (!rst) !(i_resp && d_resp));
endmodule

// File: tb/tb_cache_line_arbiter.sv
// Directed bench for cache_line_arbiter: table of single transactions plus multi-cycle sequences.
module tb_cache_line_arbiter;

  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] W1 = {8{32'h1234_5678}};
  localparam logic [255:0] W2 = {8{32'hDEAD_BEEF}};

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  i_addr = '0, d_addr = '0, mem_addr;
  logic         i_read = 1'b0, i_write = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [255:0] i_wdata = '0, d_wdata = '0, i_rdata, d_rdata, mem_wdata;
  logic         i_resp, d_resp, mem_read, mem_write;
  logic [255:0] mem_rdata = '0;
  logic         mem_resp = 1'b0;

  int total = 0;
  int bad   = 0;

  cache_line_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ir, iw; logic [31:0] ia; logic [255:0] iwd;
    logic dr, dw; logic [31:0] da; logic [255:0] dwd;
    int lat; logic [255:0] rd;
    logic own; logic [31:0] ea; logic er, ew; logic [255:0] ewd;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge of the first BUSY cycle; leaves time inside the resp cycle.
  task automatic txn(input string tag, input logic own, input logic [31:0] ea,
                     input logic er, input logic ew, input logic [255:0] ewd,
                     input int lat, input logic [255:0] rd);
    for (int c = 0; c <= lat; c++) begin
      if (c == lat) begin
        mem_rdata = rd;
        mem_resp  = 1'b1;
      end
      #1;
      chk({tag, ".mem_addr"},  mem_addr,  ea);
      chk({tag, ".mem_read"},  mem_read,  er);
      chk({tag, ".mem_write"}, mem_write, ew);
      chk({tag, ".mem_wdata"}, mem_wdata, ewd);
      chk({tag, ".i_resp"},  i_resp,  (c == lat) && !own);
      chk({tag, ".d_resp"},  d_resp,  (c == lat) && own);
      if (c < lat) @(negedge clk);
    end
    chk({tag, ".i_rdata"}, i_rdata, own ? 256'h0 : rd);
    chk({tag, ".d_rdata"}, d_rdata, own ? rd : 256'h0);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = '0;
    #1;
    chk({tag, ".idle_rd"}, mem_read, 1'b0);
    chk({tag, ".idle_wr"}, mem_write, 1'b0);
    chk({tag, ".idle_iresp"}, i_resp, 1'b0);
    chk({tag, ".idle_dresp"}, d_resp, 1'b0);
  endtask

  task automatic clear_req();
    i_read = 1'b0; i_write = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h0000_1234, 256'h0, 1'b0, 1'b0, 32'h0, 256'h0,
               5, A5, 1'b0, 32'h0000_1220, 1'b1, 1'b0, 256'h0};
    tbl[1] = '{1'b0, 1'b0, 32'h0, 256'h0, 1'b0, 1'b1, 32'h8000_0040, W1,
               3, 256'h0, 1'b1, 32'h8000_0040, 1'b0, 1'b1, W1};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_2000, 256'h0, 1'b1, 1'b0, 32'h0000_3000, 256'h0,
               2, {8{32'h2222_0000}}, 1'b0, 32'h0000_2000, 1'b1, 1'b0, 256'h0};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_2000, 256'h0, 1'b1, 1'b0, 32'h0000_301F, 256'h0,
               2, {8{32'h3333_0001}}, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 256'h0};
    tbl[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, W2, 1'b0, 1'b0, 32'h0, 256'h0,
               1, 256'h0, 1'b0, 32'hFFFF_FFE0, 1'b0, 1'b1, W2};
    tbl[5] = '{1'b0, 1'b0, 32'h0, 256'h0, 1'b1, 1'b0, 32'h0000_001F, 256'h0,
               1, {8{32'h5555_AAAA}}, 1'b1, 32'h0, 1'b1, 1'b0, 256'h0};
    tbl[6] = '{1'b0, 1'b0, 32'h0, 256'h0, 1'b1, 1'b0, 32'h0000_0060, 256'h0,
               0, {8{32'h6666_0006}}, 1'b1, 32'h0000_0060, 1'b1, 1'b0, 256'h0};

    #3;
    chk("rst.mem_read", mem_read, 1'b0);
    chk("rst.mem_write", mem_write, 1'b0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 256'h0);
    chk("rst.i_resp", i_resp, 1'b0);
    chk("rst.d_resp", d_resp, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    for (int k = 0; k < 7; k++) begin
      i_read = tbl[k].ir; i_write = tbl[k].iw; i_addr = tbl[k].ia; i_wdata = tbl[k].iwd;
      d_read = tbl[k].dr; d_write = tbl[k].dw; d_addr = tbl[k].da; d_wdata = tbl[k].dwd;
      @(negedge clk);
      txn($sformatf("tbl%0d", k), tbl[k].own, tbl[k].ea, tbl[k].er, tbl[k].ew,
          tbl[k].ewd, tbl[k].lat, tbl[k].rd);
      clear_req();
      idle_cycle($sformatf("tbl%0d", k));
    end
    i_wdata = '0; d_wdata = '0;

    // Both continuously pending: strict alternation starting with icache.
    i_read = 1'b1; i_addr = 32'h0000_4000;
    d_read = 1'b1; d_addr = 32'h0000_5008;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      txn($sformatf("alt%0d", k), k[0], (k[0] ? 32'h0000_5000 : 32'h0000_4000),
          1'b1, 1'b0, 256'h0, 2, {8{32'hC0DE_0000 + k}});
      if (k == 5) clear_req();
      idle_cycle($sformatf("alt%0d", k));
    end

    // Write-back then immediate read while icache waits.
    d_write = 1'b1; d_addr = 32'h8000_0040; d_wdata = W1;
    @(negedge clk);
    i_read = 1'b1; i_addr = 32'h0000_0644;
    txn("wb.write", 1'b1, 32'h8000_0040, 1'b0, 1'b1, W1, 3, 256'h0);
    d_write = 1'b0; d_read = 1'b1; d_addr = 32'h0000_0100;
    idle_cycle("wb.write");
    @(negedge clk);
    txn("wb.iread", 1'b0, 32'h0000_0640, 1'b1, 1'b0, 256'h0, 2, {8{32'h1111_2222}});
    i_read = 1'b0;
    idle_cycle("wb.iread");
    @(negedge clk);
    txn("wb.dread", 1'b1, 32'h0000_0100, 1'b1, 1'b0, W1, 2, {8{32'h3333_4444}});
    d_read = 1'b0; d_wdata = '0;
    idle_cycle("wb.dread");

    // Request held through the resp edge only: one transaction.
    i_read = 1'b1; i_addr = 32'h0000_0700;
    @(negedge clk);
    txn("held.a", 1'b0, 32'h0000_0700, 1'b1, 1'b0, 256'h0, 1, {8{32'h7777_0000}});
    idle_cycle("held.a");
    i_read = 1'b0;
    @(negedge clk);
    #1;
    chk("held.no_second", mem_read, 1'b0);
    // Request held into the IDLE cycle: second transaction.
    i_read = 1'b1; i_addr = 32'h0000_0720;
    @(negedge clk);
    txn("held.b1", 1'b0, 32'h0000_0720, 1'b1, 1'b0, 256'h0, 1, {8{32'h7777_0001}});
    idle_cycle("held.b1");
    @(negedge clk);
    txn("held.b2", 1'b0, 32'h0000_0720, 1'b1, 1'b0, 256'h0, 0, {8{32'h7777_0002}});
    i_read = 1'b0;
    idle_cycle("held.b2");

    // Asynchronous reset in the middle of BUSY.
    d_read = 1'b1; d_addr = 32'h0000_0900;
    @(negedge clk);
    #1;
    chk("arst.busy_rd", mem_read, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.rd_drop", mem_read, 1'b0);
    chk("arst.wr_drop", mem_write, 1'b0);
    chk("arst.addr_clr", mem_addr, 32'h0);
    d_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("arst.idle%0d", k), mem_read | mem_write, 1'b0);
    end
    mem_resp = 1'b1; mem_rdata = A5;
    #1;
    chk("arst.stray_i", i_resp, 1'b0);
    chk("arst.stray_d", d_resp, 1'b0);
    chk("arst.stray_idata", i_rdata, 256'h0);
    mem_resp = 1'b0; mem_rdata = '0;
    // last_grant returns to dcache, so icache wins the first tie.
    i_read = 1'b1; i_addr = 32'h0000_0A00;
    d_read = 1'b1; d_addr = 32'h0000_0B00;
    @(negedge clk);
    txn("arst.tie", 1'b0, 32'h0000_0A00, 1'b1, 1'b0, 256'h0, 1, {8{32'h0A0A_0A0A}});
    clear_req();
    idle_cycle("arst.tie");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
